disp_decoder: RTL and testbench
===============================

// Module: disp_decoder
// PURPOSE
//  Registered 4-bit hex to 7-segment decoder for one display digit.
//  Sits between the datapath nibble source and a board's common-anode 7-seg digit pin group.
//  Decodes all 16 codes, 0-9 and A,b,C,d,E,F, and holds the decoded pattern in output flops.
// PARAMETERS
//  SEG_ACTIVE_LOW  1  1: segment lit when output=0 (common anode); 0: lit when output=1
// PORTS
//  clk  in   1  system clock, rising-edge active
//  rst  in   1  asynchronous, active-high reset
//  x    in   1  hex code bit 3 (MSB)
//  y    in   1  hex code bit 2
//  z    in   1  hex code bit 1
//  w    in   1  hex code bit 0 (LSB)
//  a    out  1  segment a (top)
//  b    out  1  segment b (top right)
//  c    out  1  segment c (bottom right)
//  d    out  1  segment d (bottom)
//  e    out  1  segment e (bottom left)
//  f    out  1  segment f (top left)
//  g    out  1  segment g (middle)
// BEHAVIOUR
//  - Interface: one clock (clk); reset is asynchronous and active-high (rst).
//  - Reset:
//    - rst=1 immediately forces all segments off, independent of clk.
//    - "Off" is a..g=1 when SEG_ACTIVE_LOW=1, and 0 when SEG_ACTIVE_LOW=0.
//    - Outputs hold the off state while rst stays high.
//  - Operation:
//    - Code N = {x,y,z,w} is sampled on each rising clk edge while rst=0.
//    - a..g update from that same edge, so latency is 1 cycle; the outputs are glitch-free.
//    - No handshake, no enable, and no internal state other than the 7 output flops.
//  - Reset deassertion: the first rising edge after rst falls loads the pattern for the current N.
//  - Table below is the lit pattern, active-high, in order abcdefg.
//    - When SEG_ACTIVE_LOW=1 the outputs drive the bitwise inverse.
//    - 0=1111110  1=0110000  2=1101101  3=1111001
//    - 4=0110011  5=1011011  6=1011111  7=1110000
//    - 8=1111111  9=1111011  A=1110111  b=0011111
//    - C=1001110  d=0111101  E=1001111  F=1000111
//  - Glyph rules: 6 has the top bar; 9 has the bottom bar; 7 has no f segment.
//  - Input hold: an input that stays constant keeps its pattern stable on every following cycle.
//  - Unknown inputs: if any input bit is X or Z, the outputs may go X; no sanitising is needed.
//  - Glitch-free means no combinational path from x..w to a..g.
// TESTING
//  1. Reset: rst=1 with no clk edge -> a..g=1111111 (defaults); rst=0 with N=0 -> next edge a..g=0000001.
//  2. Full sweep: apply N=0..F, one per cycle -> each pattern appears 1 cycle later.
//     Examples: N=8 -> 0000000; N=b -> 1100000; N=F -> 0111000 (active-low).
//  3. Latency: change N from 1 to 2 between edges -> outputs hold 1001111 until the next rising edge.
//     Then they show 0010010.
//  4. Mid-operation reset: assert rst asynchronously while the outputs show 8 -> all 1s at once.
//     Release rst with N=E -> the next edge gives 0110000.
//  5. SEG_ACTIVE_LOW=0 build: N=3 -> 1111001; during reset -> 0000000.

Source files
------------

// File: rtl/disp_decoder_if.sv
// Nibble-in / segments-out bundle for one 7-segment digit.
// The nibble source is the master; the decoder is the slave.
interface disp_decoder_if;
    logic x;
    logic y;
    logic z;
    logic w;
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;

    modport master (
        output x, y, z, w,
        input  a, b, c, d, e, f, g
    );

    modport slave (
        input  x, y, z, w,
        output a, b, c, d, e, f, g
    );
endinterface

// File: rtl/disp_decoder.sv
// Registered hex-to-7-segment decoder for one digit.
// Only the seven output flops hold state, so no input can glitch the segments.
module disp_decoder #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    disp_decoder_if.slave  io
);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'b111_1111 : 7'b000_0000;

    logic [3:0] w_code;
    logic [6:0] w_lit;
    logic [6:0] w_drive;
    logic [6:0] r_seg;

    assign w_code = {io.x, io.y, io.z, io.w};

    // Lit pattern, active-high, ordered abcdefg.
    always_comb begin
        w_lit = 7'b000_0000;
        unique case (w_code)
            4'h0: w_lit = 7'b111_1110;
            4'h1: w_lit = 7'b011_0000;
            4'h2: w_lit = 7'b110_1101;
            4'h3: w_lit = 7'b111_1001;
            4'h4: w_lit = 7'b011_0011;
            4'h5: w_lit = 7'b101_1011;
            4'h6: w_lit = 7'b101_1111;
            4'h7: w_lit = 7'b111_0000;
            4'h8: w_lit = 7'b111_1111;
            4'h9: w_lit = 7'b111_1011;
            4'hA: w_lit = 7'b111_0111;
            4'hB: w_lit = 7'b001_1111;
            4'hC: w_lit = 7'b100_1110;
            4'hD: w_lit = 7'b011_1101;
            4'hE: w_lit = 7'b100_1111;
            4'hF: w_lit = 7'b100_0111;
            default: w_lit = 7'b000_0000;
        endcase
    end

    assign w_drive = SEG_ACTIVE_LOW ? ~w_lit : w_lit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= SEG_OFF;
        end else begin
            r_seg <= w_drive;
        end
    end

    assign io.a = r_seg[6];
    assign io.b = r_seg[5];
    assign io.c = r_seg[4];
    assign io.d = r_seg[3];
    assign io.e = r_seg[2];
    assign io.f = r_seg[1];
    assign io.g = r_seg[0];

endmodule

// File: tb/tb_disp_decoder.sv
// Directed-vector bench for disp_decoder: one common-anode build and one active-high build.
module tb_disp_decoder;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    disp_decoder_if lowIf ();
    disp_decoder_if highIf ();

    disp_decoder #(.SEG_ACTIVE_LOW(1'b1)) dutLow (
        .clk (clk),
        .rst (rst),
        .io  (lowIf.slave)
    );

    disp_decoder #(.SEG_ACTIVE_LOW(1'b0)) dutHigh (
        .clk (clk),
        .rst (rst),
        .io  (highIf.slave)
    );

    // Hand-derived segment patterns abcdefg for codes 0..F.
    logic [6:0] expLow [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [6:0] expHigh [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] segLow();
        return {lowIf.a, lowIf.b, lowIf.c, lowIf.d, lowIf.e, lowIf.f, lowIf.g};
    endfunction

    function automatic logic [6:0] segHigh();
        return {highIf.a, highIf.b, highIf.c, highIf.d, highIf.e, highIf.f, highIf.g};
    endfunction

    task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] lowCode, input logic [3:0] highCode);
        {lowIf.x, lowIf.y, lowIf.z, lowIf.w}     = lowCode;
        {highIf.x, highIf.y, highIf.z, highIf.w} = highCode;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(4'h0, 4'h3);

        // Asynchronous reset before any clock edge
        #1;
        checkOutput("rst_low_noclk", segLow(), 7'b1111111);
        checkOutput("rst_high_noclk", segHigh(), 7'b0000000);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rel_n0", segLow(), 7'b0000001);
        checkOutput("high_n3", segHigh(), 7'b1111001);

        // Full sweep, each code one cycle
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            applyStimulus(n[3:0], n[3:0]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("sweep_low_%0h", n), segLow(), expLow[n]);
            checkOutput($sformatf("sweep_high_%0h", n), segHigh(), expHigh[n]);
        end

        // Held input keeps a stable pattern
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_F", segLow(), 7'b0111000);
        end

        // One-cycle latency: mid-cycle input change must not show until next edge
        @(negedge clk);
        applyStimulus(4'h1, 4'h1);
        @(posedge clk);
        #1;
        checkOutput("lat_n1", segLow(), 7'b1001111);
        #2;
        applyStimulus(4'h2, 4'h2);
        #1;
        checkOutput("lat_hold", segLow(), 7'b1001111);
        checkOutput("lat_hold_high", segHigh(), 7'b0110000);
        @(posedge clk);
        #1;
        checkOutput("lat_n2", segLow(), 7'b0010010);

        // Mid-operation asynchronous reset while showing 8
        @(negedge clk);
        applyStimulus(4'h8, 4'h8);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_8", segLow(), 7'b0000000);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_low", segLow(), 7'b1111111);
        checkOutput("mid_rst_high", segHigh(), 7'b0000000);
        @(posedge clk);
        #1;
        checkOutput("rst_held", segLow(), 7'b1111111);
        @(negedge clk);
        applyStimulus(4'hE, 4'hE);
        rst = 1'b0;
        #1;
        checkOutput("rel_no_edge", segLow(), 7'b1111111);
        @(posedge clk);
        #1;
        checkOutput("rel_nE", segLow(), 7'b0110000);
        checkOutput("rel_nE_high", segHigh(), 7'b1001111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
